// File: rtl/memory_bus_arbiter_if.sv
// Requester, flush and memory-bus signal bundle for the memory bus arbiter.
// Latency: none, the bundle only groups wires.
// Backpressure: requests are levels held until done; bus_request_o is held until bus_done_i.
interface memory_bus_arbiter_if;
    // pipeline control
    logic        flush_i;
    // requesters
    logic        ld_req_i;
    logic        fe_req_i;
    logic        st_req_i;
    logic [31:0] ld_address_i;
    logic [31:0] fe_address_i;
    logic [31:0] st_address_i;
    logic [31:0] st_data_i;
    logic [1:0]  st_width_i;
    // completions back to the requesters
    logic        ld_done_o;
    logic        fe_done_o;
    logic        st_done_o;
    logic [31:0] rsp_data_o;
    logic        rsp_error_o;
    // external memory bus
    logic        bus_request_o;
    logic        bus_write_o;
    logic [31:0] bus_address_o;
    logic [31:0] bus_data_o;
    logic [1:0]  bus_width_o;
    logic [31:0] bus_data_i;
    logic        bus_done_i;
    logic        bus_error_i;

    // arbiter side: drives the memory bus and the completions
    modport master (
        input  flush_i,
        input  ld_req_i, fe_req_i, st_req_i,
        input  ld_address_i, fe_address_i, st_address_i,
        input  st_data_i, st_width_i,
        output ld_done_o, fe_done_o, st_done_o, rsp_data_o, rsp_error_o,
        output bus_request_o, bus_write_o, bus_address_o, bus_data_o, bus_width_o,
        input  bus_data_i, bus_done_i, bus_error_i
    );

    // environment side: requesters plus memory controller
    modport slave (
        output flush_i,
        output ld_req_i, fe_req_i, st_req_i,
        output ld_address_i, fe_address_i, st_address_i,
        output st_data_i, st_width_i,
        input  ld_done_o, fe_done_o, st_done_o, rsp_data_o, rsp_error_o,
        input  bus_request_o, bus_write_o, bus_address_o, bus_data_o, bus_width_o,
        output bus_data_i, bus_done_i, bus_error_i
    );
endinterface

// File: rtl/memory_bus_arbiter.sv
// Shares one memory bus between load, fetch and store (priority load > fetch > store).
// Latency: request to bus_request_o 1 cycle; bus_done_i to requester done 0 cycles.
// Backpressure: one transaction at a time; losers hold their level request. Optional
// store-starvation guard enabled by defining ARBITER_STARVATION_GUARD_EN.
module memory_bus_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    memory_bus_arbiter_if.master bus
);

    typedef enum logic [2:0] {IDLE, LOAD, FETCH, STORE, DRAIN} state_t;

    // Limit must fit the 1..255 range the counter width is derived from.
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_limit_check
        $error("STARVE_LIMIT out of range 1..255");
    end

    state_t      state, state_nxt;
    logic        ld_eff, fe_eff, st_eff;
    logic        arb_en, st_force;
    logic        grant_ld, grant_fe, grant_st;
    logic        bus_done_act;
    logic        bus_write_q;
    logic [31:0] bus_address_q;
    logic [31:0] bus_data_q;
    logic [1:0]  bus_width_q;

`ifdef ARBITER_STARVATION_GUARD_EN
    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_cnt;

    assign st_force = (starve_cnt == STARVE_MAX);

    // Count decisions a pending store loses; saturate, clear when store is granted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            starve_cnt <= '0;
        end else if (grant_st) begin
            starve_cnt <= '0;
        end else if (st_eff && (grant_ld || grant_fe) && !st_force) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    assign st_force = 1'b0;
`endif

    // Done from the bus only counts while a transaction owns it.
    assign bus_done_act = bus.bus_done_i &&
                          (state == LOAD || state == FETCH || state == STORE);

    // Arbitration: decide in IDLE or on completion; the finishing owner sits out that cycle.
    always_comb begin
        ld_eff   = bus.ld_req_i && (state != LOAD);
        fe_eff   = bus.fe_req_i && (state != FETCH);
        st_eff   = bus.st_req_i && (state != STORE);
        arb_en   = !bus.flush_i && ((state == IDLE) || bus_done_act);
        grant_ld = 1'b0;
        grant_fe = 1'b0;
        grant_st = 1'b0;
        if (arb_en) begin
            if (st_eff && st_force) begin
                grant_st = 1'b1;
            end else if (ld_eff) begin
                grant_ld = 1'b1;
            end else if (fe_eff) begin
                grant_fe = 1'b1;
            end else if (st_eff) begin
                grant_st = 1'b1;
            end
        end
    end

    // Next state: winner's state, DRAIN on flush of a read, IDLE when nothing is pending.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_ld)      state_nxt = LOAD;
                else if (grant_fe) state_nxt = FETCH;
                else if (grant_st) state_nxt = STORE;
            end
            LOAD, FETCH: begin
                if (bus.flush_i) begin
                    state_nxt = bus.bus_done_i ? IDLE : DRAIN;
                end else if (bus.bus_done_i) begin
                    if (grant_ld)      state_nxt = LOAD;
                    else if (grant_fe) state_nxt = FETCH;
                    else if (grant_st) state_nxt = STORE;
                    else               state_nxt = IDLE;
                end
            end
            STORE: begin
                if (bus.bus_done_i) begin
                    if (grant_ld)      state_nxt = LOAD;
                    else if (grant_fe) state_nxt = FETCH;
                    else if (grant_st) state_nxt = STORE;
                    else               state_nxt = IDLE;
                end
            end
            DRAIN: begin
                if (bus.bus_done_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // Capture the winner's transaction fields at grant; held stable while it runs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bus_write_q   <= 1'b0;
            bus_address_q <= '0;
            bus_data_q    <= '0;
            bus_width_q   <= '0;
        end else if (grant_ld) begin
            bus_write_q   <= 1'b0;
            bus_address_q <= bus.ld_address_i;
            bus_data_q    <= '0;
            bus_width_q   <= '0;
        end else if (grant_fe) begin
            bus_write_q   <= 1'b0;
            bus_address_q <= bus.fe_address_i;
            bus_data_q    <= '0;
            bus_width_q   <= '0;
        end else if (grant_st) begin
            bus_write_q   <= 1'b1;
            bus_address_q <= bus.st_address_i;
            bus_data_q    <= bus.st_data_i;
            bus_width_q   <= bus.st_width_i;
        end
    end

    assign bus.bus_request_o = (state != IDLE);
    assign bus.bus_write_o   = bus_write_q;
    assign bus.bus_address_o = bus_address_q;
    assign bus.bus_data_o    = bus_data_q;
    assign bus.bus_width_o   = bus_width_q;

    // A flushed read completes silently, whether in DRAIN or completing in the flush cycle.
    assign bus.ld_done_o   = (state == LOAD)  && bus.bus_done_i && !bus.flush_i;
    assign bus.fe_done_o   = (state == FETCH) && bus.bus_done_i && !bus.flush_i;
    assign bus.st_done_o   = (state == STORE) && bus.bus_done_i;
    assign bus.rsp_data_o  = (bus.ld_done_o || bus.fe_done_o) ? bus.bus_data_i : 32'h0;
    assign bus.rsp_error_o = (bus.ld_done_o || bus.fe_done_o || bus.st_done_o) ?
                             bus.bus_error_i : 1'b0;

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Directed bench for memory_bus_arbiter with hand-computed expectations.
// Latency: checks grant 1 cycle after request, done in the bus_done_i cycle.
// Backpressure: bus completions are driven by hand; every step is a fixed cycle count.
module tb_memory_bus_arbiter;

    logic clk_i;
    logic rst_i;
    int   n_checks;
    int   n_errors;

    memory_bus_arbiter_if bif ();

    memory_bus_arbiter #(.STARVE_LIMIT(3)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bif)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h want %h", tag, got, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk_i);
        #2;
    endtask

    logic [2:0] owner_exp [6];
    logic [2:0] done_bits;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_i = 1'b1;
        bif.flush_i = 0;
        bif.ld_req_i = 0; bif.fe_req_i = 0; bif.st_req_i = 0;
        bif.ld_address_i = 0; bif.fe_address_i = 0; bif.st_address_i = 0;
        bif.st_data_i = 0; bif.st_width_i = 0;
        bif.bus_data_i = 32'hCAFE_F00D; bif.bus_done_i = 1; bif.bus_error_i = 1;

        // reset state: all outputs low even with a stray bus_done_i
        cyc(); cyc();
        #1;
        check("rst_req",   {31'b0, bif.bus_request_o}, 0);
        check("rst_write", {31'b0, bif.bus_write_o}, 0);
        check("rst_addr",  bif.bus_address_o, 0);
        check("rst_data",  bif.bus_data_o, 0);
        check("rst_width", {30'b0, bif.bus_width_o}, 0);
        check("rst_dones", {29'b0, bif.st_done_o, bif.fe_done_o, bif.ld_done_o}, 0);
        check("rst_rsp",   bif.rsp_data_o, 0);
        check("rst_err",   {31'b0, bif.rsp_error_o}, 0);
        bif.bus_done_i = 0; bif.bus_error_i = 0;
        rst_i = 1'b0;
        cyc();

        // single load
        bif.ld_req_i = 1; bif.ld_address_i = 32'h100;
        cyc(); #1;
        check("ld_req",   {31'b0, bif.bus_request_o}, 1);
        check("ld_write", {31'b0, bif.bus_write_o}, 0);
        check("ld_addr",  bif.bus_address_o, 32'h100);
        bif.bus_data_i = 32'hDEAD_BEEF; bif.bus_done_i = 1;
        #1;
        check("ld_done",  {31'b0, bif.ld_done_o}, 1);
        check("ld_rdata", bif.rsp_data_o, 32'hDEAD_BEEF);
        check("ld_fedone", {31'b0, bif.fe_done_o}, 0);
        cyc();
        bif.ld_req_i = 0; bif.bus_done_i = 0;
        #1;
        check("ld_idle", {31'b0, bif.bus_request_o}, 0);

        // simultaneous load + fetch + store: load, fetch, store with no bubble
        bif.ld_req_i = 1; bif.ld_address_i = 32'h10;
        bif.fe_req_i = 1; bif.fe_address_i = 32'h20;
        bif.st_req_i = 1; bif.st_address_i = 32'h30;
        bif.st_data_i = 32'h1357_9BDF; bif.st_width_i = 2'd1;
        cyc(); #1;
        check("seq1_addr", bif.bus_address_o, 32'h10);
        bif.bus_done_i = 1; bif.bus_data_i = 32'h0000_0011;
        #1;
        check("seq1_done", {29'b0, bif.st_done_o, bif.fe_done_o, bif.ld_done_o}, 3'b001);
        cyc();
        bif.ld_req_i = 0; bif.bus_done_i = 0;
        #1;
        check("seq2_req",  {31'b0, bif.bus_request_o}, 1);
        check("seq2_addr", bif.bus_address_o, 32'h20);
        bif.bus_done_i = 1; bif.bus_data_i = 32'h0000_0022;
        #1;
        check("seq2_done", {29'b0, bif.st_done_o, bif.fe_done_o, bif.ld_done_o}, 3'b010);
        check("seq2_rdata", bif.rsp_data_o, 32'h22);
        cyc();
        bif.fe_req_i = 0; bif.bus_done_i = 0;
        #1;
        check("seq3_req",   {31'b0, bif.bus_request_o}, 1);
        check("seq3_addr",  bif.bus_address_o, 32'h30);
        check("seq3_write", {31'b0, bif.bus_write_o}, 1);
        check("seq3_wdata", bif.bus_data_o, 32'h1357_9BDF);
        check("seq3_width", {30'b0, bif.bus_width_o}, 1);
        bif.bus_done_i = 1;
        #1;
        check("seq3_done", {29'b0, bif.st_done_o, bif.fe_done_o, bif.ld_done_o}, 3'b100);
        cyc();
        bif.st_req_i = 0; bif.bus_done_i = 0;
        #1;
        check("seq_idle", {31'b0, bif.bus_request_o}, 0);

        // flush mid-load: request held through DRAIN, no ld_done
        bif.ld_req_i = 1; bif.ld_address_i = 32'h140;
        cyc(); #1;
        check("fl_grant", {31'b0, bif.bus_request_o}, 1);
        cyc(); cyc();
        bif.flush_i = 1; bif.ld_req_i = 0;
        cyc();
        bif.flush_i = 0;
        #1;
        check("fl_hold1", {31'b0, bif.bus_request_o}, 1);
        cyc(); #1;
        check("fl_hold2", {31'b0, bif.bus_request_o}, 1);
        cyc();
        bif.bus_done_i = 1; bif.bus_data_i = 32'h1234_5678;
        #1;
        check("fl_nodone", {31'b0, bif.ld_done_o}, 0);
        check("fl_rsp",    bif.rsp_data_o, 0);
        cyc();
        bif.bus_done_i = 0;
        #1;
        check("fl_idle", {31'b0, bif.bus_request_o}, 0);

        // flush in IDLE blocks the grant for that cycle
        bif.fe_req_i = 1; bif.fe_address_i = 32'h180; bif.flush_i = 1;
        cyc();
        bif.flush_i = 0;
        #1;
        check("flidle_block", {31'b0, bif.bus_request_o}, 0);
        cyc(); #1;
        check("flidle_grant", bif.bus_address_o, 32'h180);
        bif.bus_done_i = 1;
        cyc();
        bif.fe_req_i = 0; bif.bus_done_i = 0;

        // store with bus error; flush during STORE is ignored
        bif.st_req_i = 1; bif.st_address_i = 32'h200;
        bif.st_data_i = 32'h55AA; bif.st_width_i = 2'd2;
        cyc(); #1;
        check("st_width", {30'b0, bif.bus_width_o}, 2);
        check("st_addr",  bif.bus_address_o, 32'h200);
        check("st_wdata", bif.bus_data_o, 32'h55AA);
        bif.flush_i = 1;
        cyc(); #1;
        check("st_flush_hold", {31'b0, bif.bus_request_o}, 1);
        bif.bus_done_i = 1; bif.bus_error_i = 1;
        #1;
        check("st_done", {31'b0, bif.st_done_o}, 1);
        check("st_err",  {31'b0, bif.rsp_error_o}, 1);
        cyc();
        bif.flush_i = 0; bif.st_req_i = 0; bif.bus_done_i = 0; bif.bus_error_i = 0;
        #1;
        check("st_idle", {31'b0, bif.bus_request_o}, 0);

        // starvation: load and fetch alternate with the store held pending
`ifdef ARBITER_STARVATION_GUARD_EN
        owner_exp = '{3'b001, 3'b010, 3'b001, 3'b100, 3'b001, 3'b010};
`else
        owner_exp = '{3'b001, 3'b010, 3'b001, 3'b010, 3'b001, 3'b010};
`endif
        bif.ld_req_i = 1; bif.fe_req_i = 1; bif.st_req_i = 1;
        bif.ld_address_i = 32'h400; bif.fe_address_i = 32'h500; bif.st_address_i = 32'h600;
        cyc();
        bif.bus_done_i = 1;
        for (int k = 0; k < 6; k++) begin
            #1;
            done_bits = {bif.st_done_o, bif.fe_done_o, bif.ld_done_o};
            check($sformatf("starve_%0d", k), {29'b0, done_bits}, {29'b0, owner_exp[k]});
            cyc();
        end
        bif.ld_req_i = 0; bif.fe_req_i = 0; bif.st_req_i = 0;
        cyc();
        bif.bus_done_i = 0;
        #1;
        check("starve_idle", {31'b0, bif.bus_request_o}, 0);

        // reset during STORE: outputs drop at once, late done ignored
        bif.st_req_i = 1; bif.st_address_i = 32'h300;
        bif.st_data_i = 32'hAB; bif.st_width_i = 2'd1;
        cyc(); #1;
        check("rs_active", {31'b0, bif.bus_request_o}, 1);
        rst_i = 1'b1;
        #1;
        check("rs_req",   {31'b0, bif.bus_request_o}, 0);
        check("rs_write", {31'b0, bif.bus_write_o}, 0);
        check("rs_addr",  bif.bus_address_o, 0);
        check("rs_wdata", bif.bus_data_o, 0);
        check("rs_width", {30'b0, bif.bus_width_o}, 0);
        bif.st_req_i = 0;
        cyc();
        rst_i = 1'b0;
        cyc();
        bif.bus_done_i = 1; bif.bus_error_i = 1;
        #1;
        check("rs_late_done", {31'b0, bif.st_done_o}, 0);
        check("rs_late_err",  {31'b0, bif.rsp_error_o}, 0);
        cyc();
        bif.bus_done_i = 0; bif.bus_error_i = 0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
